jtag_tap_multi_dr: RTL and testbench
====================================

# jtag_tap_multi_dr

Parametrised JTAG test access port: TAP controller, IR_WIDTH-bit instruction register and a data-register bank with BYPASS, IDCODE and NUM_DR user data registers of DR_WIDTH bits each. Sits at the chip pins and is the front end for downstream debug logic such as the JTAG-to-AXI bridge. User registers are read through capture inputs and written through one-cycle update strobes, all in the tck domain.

## Interface
- IR_WIDTH, 4: instruction register width; must be ≥ 2.
- IDCODE_VAL, 32'h1000_0AFF: IDCODE register content; bit 0 must be 1.
- NUM_DR, 2: number of user data registers; must be 1 to 2^IR_WIDTH−3.
- DR_WIDTH, 32: width of every user data register.
- tck  in  1  JTAG clock; the only clock.
- trstn  in  1  asynchronous, active-low reset.
- tms  in  1  mode select, sampled on rising tck.
- tdi  in  1  serial data in, sampled on rising tck.
- tdo  out  1  serial data out, updated on falling tck.
- tdo_en  out  1  high while tdo carries valid shift data.
- tap_state  out  tap_ctrl_fsm_t  current TAP state.
- ir_value  out  IR_WIDTH  active (updated) instruction.
- dr_sel  out  NUM_DR  one-hot select of the addressed user DR; zero otherwise.
- dr_capture_data  in  NUM_DR*DR_WIDTH  parallel load for each user DR; slice k belongs to DR k.
- dr_update_data  out  DR_WIDTH  shift-register content at the last Update-DR.
- dr_update_valid  out  NUM_DR  one-tck pulse on the addressed user DR at Update-DR.

## Operation
- TAP FSM follows the standard 16 IEEE 1149.1 states and transitions. Five consecutive tms=1 rising edges reach Test-Logic-Reset from any state.
- Opcode map:
  - IDCODE = 1.
  - User DR k = 2+k.
  - BYPASS = all ones.
  - Any other opcode, including 0, selects BYPASS.
- IR:
  - Capture-IR loads the shift register with {zeros, 2'b01}.
  - Shift-IR shifts LSB first: tdi enters the MSB; the LSB goes to tdo.
  - Update-IR copies the shift register to ir_value.
  - Test-Logic-Reset forces ir_value = IDCODE.
- BYPASS: 1-bit register; Capture-DR loads 0; in Shift-DR it gives a one-bit tdi-to-tdo delay.
- IDCODE: 32-bit shift register; Capture-DR loads IDCODE_VAL; shifts LSB first. tdi fills the MSB, so extra shifting echoes tdi.
- User DR k:
  - A single shared DR_WIDTH shift register serves all user DRs.
  - Capture-DR loads slice k of dr_capture_data.
  - Shift-DR shifts LSB first.
  - Update-DR copies the register to dr_update_data and pulses dr_update_valid[k].
- dr_sel tracks ir_value combinationally.
- Exit/Pause states hold all shift registers unchanged.
- Test-Logic-Reset and Run-Test/Idle do not alter dr_update_data.

## Timing
- Reset values while trstn=0:
  - tap_state = Test-Logic-Reset.
  - ir_value = IDCODE.
  - All shift registers = 0.
  - tdo = 0, tdo_en = 0.
  - dr_update_data = 0, dr_update_valid = 0.
- Reset is asynchronous on assertion and released synchronously on rising tck. Reset in the middle of a shift discards the shift; no update pulse is issued.
- Capture, shift and update take effect on the rising tck that exits the respective state.
- tdo and tdo_en are registered on falling tck:
  - tdo_en = 1 exactly while tap_state is Shift-IR or Shift-DR.
  - Otherwise tdo = 0 and tdo_en = 0.
- The first tdo bit of a scan is valid after the falling edge following entry into Shift-xR. Capture-to-first-bit latency is half a tck.
- dr_update_valid is high for exactly the one tck cycle after the rising edge leaving Update-DR. It rises only if the active instruction is a user DR.
- An IR update takes effect on the next Capture-DR. No DR state is altered by an IR scan.

## Structure
- jtag_pkg holds:
  - tap_ctrl_fsm_t.
  - The IDCODE and BYPASS opcode constants.
  - The user-DR base opcode (2).
- Sub-module: instantiate the existing tap_ctrl_fsm for the state machine.
- jtag_tap_multi_dr holds the IR, the DR bank and the tdo mux.
- Parameter legality is checked by elaboration-time assertions.

## Test plan
- Reset, then drive five tms=1 clocks: expect ir_value=4'h1, tdo_en=0, tap_state=Test-Logic-Reset.
- From reset, scan DR 32 bits with tdi=0: expect 32'h1000_0AFF shifted out LSB first.
- IR scan shifting in 4'hF: expect tdo sequence 1,0,0,0; then ir_value=4'hF. Then a DR scan of pattern 1011 with 1 bit of delay: expect 0,1,0,1,1.
- Load IR=4'h2 and dr_capture_data slice 0 = 32'hCAFE_F00D. DR scan shifting in 32'h1234_5678: expect tdo = 32'hCAFE_F00D; at Update-DR expect dr_update_data=32'h1234_5678 and a one-cycle dr_update_valid=2'b01.
- Load IR=4'h3 and shift a DR through Pause-DR/Exit2-DR mid-scan: expect no corruption, and dr_update_valid=2'b10 only at Update-DR.
- Assert trstn in the middle of a Shift-DR of a user DR: expect immediate Test-Logic-Reset, ir_value=4'h1, no dr_update_valid, dr_update_data unchanged from its prior value.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared JTAG types and opcode constants for the TAP and its state machine.
package jtag_pkg;

  typedef enum logic [3:0] {
    TAP_RESET,
    TAP_IDLE,
    TAP_SEL_DR,
    TAP_CAP_DR,
    TAP_SHIFT_DR,
    TAP_EXIT1_DR,
    TAP_PAUSE_DR,
    TAP_EXIT2_DR,
    TAP_UPDATE_DR,
    TAP_SEL_IR,
    TAP_CAP_IR,
    TAP_SHIFT_IR,
    TAP_EXIT1_IR,
    TAP_PAUSE_IR,
    TAP_EXIT2_IR,
    TAP_UPDATE_IR
  } tap_ctrl_fsm_t;

  localparam int unsigned IDCODE_W = 32;

  // Opcodes are held 32 bits wide and sliced down to the IR width by the user.
  localparam logic [31:0] OPC_IDCODE  = 32'd1;
  localparam logic [31:0] OPC_DR_BASE = 32'd2;
  localparam logic [31:0] OPC_BYPASS  = '1;

endpackage

// File: rtl/tap_ctrl_fsm.sv
// IEEE 1149.1 TAP controller: the 16-state machine driven by tms on rising tck.
module tap_ctrl_fsm
  import jtag_pkg::*;
(
  input  logic          tck,
  input  logic          trstn,
  input  logic          tms,
  output tap_ctrl_fsm_t state
);

  tap_ctrl_fsm_t r_state;
  tap_ctrl_fsm_t w_next;

  // State register; trstn forces Test-Logic-Reset immediately.
  always_ff @(posedge tck or negedge trstn) begin
    if (!trstn) r_state <= TAP_RESET;
    else        r_state <= w_next;
  end

  // Standard TAP transition table.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      TAP_RESET:     w_next = tms ? TAP_RESET     : TAP_IDLE;
      TAP_IDLE:      w_next = tms ? TAP_SEL_DR    : TAP_IDLE;
      TAP_SEL_DR:    w_next = tms ? TAP_SEL_IR    : TAP_CAP_DR;
      TAP_CAP_DR:    w_next = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_SHIFT_DR:  w_next = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_EXIT1_DR:  w_next = tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
      TAP_PAUSE_DR:  w_next = tms ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
      TAP_EXIT2_DR:  w_next = tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
      TAP_UPDATE_DR: w_next = tms ? TAP_SEL_DR    : TAP_IDLE;
      TAP_SEL_IR:    w_next = tms ? TAP_RESET     : TAP_CAP_IR;
      TAP_CAP_IR:    w_next = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_SHIFT_IR:  w_next = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_EXIT1_IR:  w_next = tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
      TAP_PAUSE_IR:  w_next = tms ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
      TAP_EXIT2_IR:  w_next = tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
      TAP_UPDATE_IR: w_next = tms ? TAP_SEL_DR    : TAP_IDLE;
      default:       w_next = TAP_RESET;
    endcase
  end

  assign state = r_state;

endmodule

// File: rtl/jtag_tap_multi_dr.sv
// JTAG TAP with instruction register, BYPASS, IDCODE and a bank of user DRs
// sharing one shift register. Everything runs in the tck domain.
module jtag_tap_multi_dr
  import jtag_pkg::*;
#(
  parameter int unsigned IR_WIDTH   = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0AFF,
  parameter int unsigned NUM_DR     = 2,
  parameter int unsigned DR_WIDTH   = 32
) (
  input  logic                       tck,
  input  logic                       trstn,
  input  logic                       tms,
  input  logic                       tdi,
  output logic                       tdo,
  output logic                       tdo_en,
  output tap_ctrl_fsm_t              tap_state,
  output logic [IR_WIDTH-1:0]        ir_value,
  output logic [NUM_DR-1:0]          dr_sel,
  input  logic [NUM_DR*DR_WIDTH-1:0] dr_capture_data,
  output logic [DR_WIDTH-1:0]        dr_update_data,
  output logic [NUM_DR-1:0]          dr_update_valid
);

  if (IR_WIDTH < 2) begin : g_chk_ir_width
    $error("IR_WIDTH must be at least 2");
  end
  if (IDCODE_VAL[0] != 1'b1) begin : g_chk_idcode
    $error("IDCODE_VAL bit 0 must be 1");
  end
  if (NUM_DR < 1 || NUM_DR > (2 ** IR_WIDTH) - 3) begin : g_chk_num_dr
    $error("NUM_DR must be in 1 .. 2**IR_WIDTH-3");
  end
  if (DR_WIDTH < 1) begin : g_chk_dr_width
    $error("DR_WIDTH must be at least 1");
  end

  localparam logic [IR_WIDTH-1:0] LP_OPC_IDCODE = OPC_IDCODE[IR_WIDTH-1:0];
  localparam logic [IR_WIDTH-1:0] LP_OPC_BASE   = OPC_DR_BASE[IR_WIDTH-1:0];
  localparam logic [IR_WIDTH-1:0] LP_NUM_DR     = IR_WIDTH'(NUM_DR);

  tap_ctrl_fsm_t         w_state;
  logic [IR_WIDTH-1:0]   r_ir_sr;
  logic [IR_WIDTH-1:0]   r_ir_value;
  logic                  r_bypass;
  logic [IDCODE_W-1:0]   r_id_sr;
  logic [DR_WIDTH-1:0]   r_user_sr;
  logic [DR_WIDTH-1:0]   r_dr_update_data;
  logic [NUM_DR-1:0]     r_dr_update_valid;
  logic                  r_tdo;
  logic                  r_tdo_en;
  logic [IR_WIDTH-1:0]   w_user_off;
  logic                  w_is_user;
  logic                  w_is_idcode;
  logic [NUM_DR-1:0]     w_dr_sel;
  logic [DR_WIDTH-1:0]   w_cap_data;
  logic                  w_dr_lsb;

  tap_ctrl_fsm u_tap_ctrl_fsm (
    .tck   (tck),
    .trstn (trstn),
    .tms   (tms),
    .state (w_state)
  );

  // Unused and out-of-range opcodes fall through to BYPASS.
  assign w_user_off  = r_ir_value - LP_OPC_BASE;
  assign w_is_user   = (r_ir_value >= LP_OPC_BASE) && (w_user_off < LP_NUM_DR);
  assign w_is_idcode = (r_ir_value == LP_OPC_IDCODE);

  // One-hot user DR select and the matching capture slice.
  always_comb begin
    w_dr_sel   = '0;
    w_cap_data = '0;
    for (int unsigned k = 0; k < NUM_DR; k++) begin
      if (w_is_user && (w_user_off == IR_WIDTH'(k))) begin
        w_dr_sel[k] = 1'b1;
        w_cap_data  = dr_capture_data[k*DR_WIDTH +: DR_WIDTH];
      end
    end
  end

  assign w_dr_lsb = w_is_user   ? r_user_sr[0] :
                    w_is_idcode ? r_id_sr[0]   : r_bypass;

  // Instruction register: capture, shift and update on the exiting edge.
  always_ff @(posedge tck or negedge trstn) begin
    if (!trstn) begin
      r_ir_sr    <= '0;
      r_ir_value <= LP_OPC_IDCODE;
    end else begin
      case (w_state)
        TAP_RESET:     r_ir_value <= LP_OPC_IDCODE;
        TAP_CAP_IR:    r_ir_sr    <= IR_WIDTH'(2'b01);
        TAP_SHIFT_IR:  r_ir_sr    <= {tdi, r_ir_sr[IR_WIDTH-1:1]};
        TAP_UPDATE_IR: r_ir_value <= r_ir_sr;
        default:       ;
      endcase
    end
  end

  // Data register bank: only the register addressed by the IR captures/shifts.
  always_ff @(posedge tck or negedge trstn) begin
    if (!trstn) begin
      r_bypass  <= 1'b0;
      r_id_sr   <= '0;
      r_user_sr <= '0;
    end else if (w_state == TAP_CAP_DR) begin
      if (w_is_user)        r_user_sr <= w_cap_data;
      else if (w_is_idcode) r_id_sr   <= IDCODE_VAL;
      else                  r_bypass  <= 1'b0;
    end else if (w_state == TAP_SHIFT_DR) begin
      if (w_is_user)        r_user_sr <= {tdi, r_user_sr[DR_WIDTH-1:1]};
      else if (w_is_idcode) r_id_sr   <= {tdi, r_id_sr[IDCODE_W-1:1]};
      else                  r_bypass  <= tdi;
    end
  end

  // Update-DR publishes the user shift register with a one-cycle strobe.
  always_ff @(posedge tck or negedge trstn) begin
    if (!trstn) begin
      r_dr_update_data  <= '0;
      r_dr_update_valid <= '0;
    end else begin
      r_dr_update_valid <= '0;
      if (w_state == TAP_UPDATE_DR && w_is_user) begin
        r_dr_update_data  <= r_user_sr;
        r_dr_update_valid <= w_dr_sel;
      end
    end
  end

  // tdo is launched on falling tck so it is stable for the next rising edge.
  always_ff @(negedge tck or negedge trstn) begin
    if (!trstn) begin
      r_tdo    <= 1'b0;
      r_tdo_en <= 1'b0;
    end else begin
      case (w_state)
        TAP_SHIFT_IR: begin
          r_tdo    <= r_ir_sr[0];
          r_tdo_en <= 1'b1;
        end
        TAP_SHIFT_DR: begin
          r_tdo    <= w_dr_lsb;
          r_tdo_en <= 1'b1;
        end
        default: begin
          r_tdo    <= 1'b0;
          r_tdo_en <= 1'b0;
        end
      endcase
    end
  end

  assign tdo             = r_tdo;
  assign tdo_en          = r_tdo_en;
  assign tap_state       = w_state;
  assign ir_value        = r_ir_value;
  assign dr_sel          = w_dr_sel;
  assign dr_update_data  = r_dr_update_data;
  assign dr_update_valid = r_dr_update_valid;

endmodule

// File: tb/tb_jtag_tap_multi_dr.sv
// Directed bench for jtag_tap_multi_dr with hand-computed expectations.
module tb_jtag_tap_multi_dr;
  import jtag_pkg::*;

  logic          tck;
  logic          trstn;
  logic          tms;
  logic          tdi;
  logic          tdo;
  logic          tdo_en;
  tap_ctrl_fsm_t tap_state;
  logic [3:0]    ir_value;
  logic [1:0]    dr_sel;
  logic [63:0]   dr_capture_data;
  logic [31:0]   dr_update_data;
  logic [1:0]    dr_update_valid;

  int unsigned n_total;
  int unsigned n_bad;

  jtag_tap_multi_dr #(
    .IR_WIDTH   (4),
    .IDCODE_VAL (32'h1000_0AFF),
    .NUM_DR     (2),
    .DR_WIDTH   (32)
  ) dut (
    .tck             (tck),
    .trstn           (trstn),
    .tms             (tms),
    .tdi             (tdi),
    .tdo             (tdo),
    .tdo_en          (tdo_en),
    .tap_state       (tap_state),
    .ir_value        (ir_value),
    .dr_sel          (dr_sel),
    .dr_capture_data (dr_capture_data),
    .dr_update_data  (dr_update_data),
    .dr_update_valid (dr_update_valid)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One tck: inputs sampled on the rise, outputs observed after the fall.
  task automatic step(input logic t, input logic d);
    tms = t;
    tdi = d;
    @(posedge tck);
    @(negedge tck);
    #1;
  endtask

  // Shift n bits starting in Shift-xR; tms=1 on the last bit when do_exit.
  task automatic shift_bits(input int n, input logic [63:0] din, input bit do_exit,
                            output logic [63:0] dout);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n; i++) begin
      v[i] = tdo;
      step(do_exit && (i == n - 1), din[i]);
    end
    dout = v;
  endtask

  task automatic idle_to_shift_dr();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  // IR load from Run-Test/Idle, ending back in Run-Test/Idle.
  task automatic load_ir(input logic [3:0] op, output logic [63:0] dout);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    shift_bits(4, {60'h0, op}, 1'b1, dout);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  logic [63:0] out_a;
  logic [63:0] out_b;

  initial begin
    n_total = 0;
    n_bad   = 0;
    trstn   = 1'b0;
    tms     = 1'b1;
    tdi     = 1'b0;
    dr_capture_data = {32'hA5A5_0F0F, 32'hCAFE_F00D};

    // Reset values while trstn is low.
    @(negedge tck);
    @(negedge tck);
    #1;
    chk("rst_state", 64'(tap_state), 64'(TAP_RESET));
    chk("rst_ir", 64'(ir_value), 64'h1);
    chk("rst_tdo", 64'({tdo, tdo_en}), 64'h0);
    chk("rst_upd", 64'({dr_update_data, dr_update_valid}), 64'h0);
    chk("rst_sel", 64'(dr_sel), 64'h0);
    trstn = 1'b1;

    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    chk("tlr_state", 64'(tap_state), 64'(TAP_RESET));
    chk("tlr_ir", 64'(ir_value), 64'h1);
    chk("tlr_tdo_en", 64'(tdo_en), 64'h0);

    // IDCODE read straight out of reset.
    step(1'b0, 1'b0);
    idle_to_shift_dr();
    chk("sdr_state", 64'(tap_state), 64'(TAP_SHIFT_DR));
    chk("sdr_tdo_en", 64'(tdo_en), 64'h1);
    shift_bits(32, 64'h0, 1'b1, out_a);
    chk("idcode", out_a, 64'h1000_0AFF);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("idcode_nvalid", 64'(dr_update_valid), 64'h0);
    chk("idle_tdo_en", 64'(tdo_en), 64'h0);

    // IR capture pattern and BYPASS delay.
    load_ir(4'hF, out_a);
    chk("ir_capture", out_a, 64'h1);
    chk("ir_f", 64'(ir_value), 64'hF);
    chk("sel_bypass", 64'(dr_sel), 64'h0);
    idle_to_shift_dr();
    shift_bits(5, 64'b01101, 1'b1, out_a);
    chk("bypass", out_a, 64'b11010);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // User DR 0 capture/update.
    load_ir(4'h2, out_a);
    chk("ir_2", 64'(ir_value), 64'h2);
    chk("sel_dr0", 64'(dr_sel), 64'h1);
    idle_to_shift_dr();
    shift_bits(32, 64'h1234_5678, 1'b1, out_a);
    chk("dr0_capture", out_a, 64'hCAFE_F00D);
    step(1'b1, 1'b0);
    chk("dr0_valid_early", 64'(dr_update_valid), 64'h0);
    step(1'b0, 1'b0);
    chk("dr0_valid", 64'(dr_update_valid), 64'h1);
    chk("dr0_data", 64'(dr_update_data), 64'h1234_5678);
    step(1'b0, 1'b0);
    chk("dr0_valid_off", 64'(dr_update_valid), 64'h0);

    // User DR 1 with a Pause-DR detour mid-scan.
    load_ir(4'h3, out_a);
    chk("sel_dr1", 64'(dr_sel), 64'h2);
    idle_to_shift_dr();
    shift_bits(12, 64'h89AB_CDEF, 1'b1, out_a);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("pause_state", 64'(tap_state), 64'(TAP_PAUSE_DR));
    chk("pause_tdo_en", 64'(tdo_en), 64'h0);
    chk("pause_valid", 64'(dr_update_valid), 64'h0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    shift_bits(20, 64'h89AB_CDEF >> 12, 1'b1, out_b);
    chk("dr1_capture", {out_b[51:0], out_a[11:0]}, 64'hA5A5_0F0F);
    step(1'b1, 1'b0);
    chk("dr1_valid_early", 64'(dr_update_valid), 64'h0);
    step(1'b0, 1'b0);
    chk("dr1_valid", 64'(dr_update_valid), 64'h2);
    chk("dr1_data", 64'(dr_update_data), 64'h89AB_CDEF);
    step(1'b0, 1'b0);
    chk("dr1_valid_off", 64'(dr_update_valid), 64'h0);

    // Publish an all-zero word, then abort a later scan with trstn.
    idle_to_shift_dr();
    shift_bits(32, 64'h0, 1'b1, out_a);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("zero_data", 64'(dr_update_data), 64'h0);
    idle_to_shift_dr();
    shift_bits(10, 64'h3FF, 1'b0, out_a);
    chk("pre_rst_state", 64'(tap_state), 64'(TAP_SHIFT_DR));
    #2;
    trstn = 1'b0;
    #1;
    chk("arst_state", 64'(tap_state), 64'(TAP_RESET));
    chk("arst_ir", 64'(ir_value), 64'h1);
    chk("arst_tdo", 64'({tdo, tdo_en}), 64'h0);
    chk("arst_upd", 64'({dr_update_data, dr_update_valid}), 64'h0);
    step(1'b1, 1'b0);
    trstn = 1'b1;
    step(1'b0, 1'b0);
    chk("post_rst_state", 64'(tap_state), 64'(TAP_IDLE));
    chk("post_rst_upd", 64'({dr_update_data, dr_update_valid}), 64'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
